mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported data memory behind the MEM stage. It shares the memory between two requesters: the pipeline MEM stage (port P) and a loader/debug port (port D). It drives a fixed-latency memory through an IDLE/ACCESS/RESP state machine and freezes the pipeline with `p_stall` until the MEM-stage access completes. A starvation counter guarantees port D forward progress despite pipeline priority.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data memory between the MEM stage (P) and the loader/debug port (D).
// Fixed-latency IDLE/ACCESS/RESP sequencer; a starve counter lets a waiting D past a busy pipeline.
module mem_port_arbiter #(
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_read,
  input  logic        p_write,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_stall,
  output logic [31:0] p_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        winD;
  logic        capWe;
  logic [31:0] capAddr;
  logic [31:0] capWdata;
  logic [31:0] respData;
  logic [3:0]  cnt;
  logic [3:0]  starveCnt;

  logic pReq;
  logic starved;
  logic dWins;

  assign pReq    = p_read | p_write;
  assign starved = (starveCnt == 4'(STARVE));
  assign dWins   = d_req & (~pReq | starved);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      winD      <= 1'b0;
      capWe     <= 1'b0;
      capAddr   <= '0;
      capWdata  <= '0;
      respData  <= '0;
      cnt       <= '0;
      starveCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!d_req) starveCnt <= '0;
          if (pReq | d_req) begin
            state <= ACCESS;
            cnt   <= 4'(LAT - 1);
            winD  <= dWins;
            if (dWins) begin
              capAddr   <= d_addr;
              capWdata  <= d_wdata;
              capWe     <= d_we;
              starveCnt <= '0;
            end else begin
              capAddr  <= p_addr;
              capWdata <= p_wdata;
              // both strobes high counts as a store
              capWe    <= p_write;
              if (d_req && !starved) starveCnt <= starveCnt + 4'd1;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!capWe) respData <= mem_rdata;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from reset-cleared state, so they drop as soon as reset asserts.
  assign mem_read  = (state == ACCESS) & ~capWe;
  assign mem_write = (state == ACCESS) &  capWe;
  assign mem_addr  = capAddr;
  assign mem_wdata = capWdata;

  assign p_stall = pReq & ~((state == RESP) & ~winD);
  assign p_rdata = respData;
  assign d_ack   = (state == RESP) & winD;
  assign d_rdata = respData;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers queue expected responses, a negedge monitor retires them.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_read, p_write, d_req, d_we;
  logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
  logic        p_stall, d_ack, mem_read, mem_write;
  logic [31:0] p_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.LAT(LAT), .STARVE(4)) dut (
    .clk(clk), .reset(reset),
    .p_read(p_read), .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // word-addressed memory model
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t pQ[$];
  exp_t dQ[$];
  int passCnt = 0;
  int totalCnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  int          accessCnt = 0;
  logic [31:0] lastAddr, lastWd;
  logic        lastWe;

  function automatic void score(string who, exp_t e, logic [31:0] rdata);
    check({who, "_cycle"}, 32'(cyc), 32'(e.cyc));
    check({who, "_strobe_len"}, 32'(accessCnt), 32'(LAT));
    check({who, "_addr"}, lastAddr, e.addr);
    check({who, "_we"}, 32'(lastWe), 32'(e.we));
    if (e.we) check({who, "_wdata"}, lastWd, e.wdata);
    else      check({who, "_rdata"}, rdata, e.rdata);
    accessCnt = 0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) accessCnt = 0;
    else begin
      if (mem_read | mem_write) begin
        accessCnt++;
        lastAddr = mem_addr;
        lastWe   = mem_write;
        lastWd   = mem_wdata;
      end
      if ((p_read | p_write) && !p_stall) begin
        if (pQ.size() == 0) check("p_unexpected_resp", 1, 0);
        else begin e = pQ.pop_front(); score("p", e, p_rdata); end
      end
      if (d_ack) begin
        check("d_ack_pstall", 32'(p_stall), 32'(p_read | p_write));
        if (dQ.size() == 0) check("d_unexpected_ack", 1, 0);
        else begin e = dQ.pop_front(); score("d", e, d_rdata); end
      end
    end
  end

  task automatic pIssue(input logic we, input logic [31:0] addr, wdata, rdata, input int delay);
    exp_t e;
    int n;
    @(posedge clk); #1;
    p_read = ~we; p_write = we; p_addr = addr; p_wdata = wdata;
    e.cyc = cyc + delay; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    pQ.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (p_stall && n < 100);
    if (p_stall) check("p_timeout", 32'(p_stall), 0);
  endtask

  task automatic pIdle();
    @(posedge clk); #1;
    p_read = 1'b0; p_write = 1'b0;
  endtask

  task automatic dIssue(input logic we, input logic [31:0] addr, wdata, rdata, input int delay);
    exp_t e;
    int n;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    e.cyc = cyc + delay; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    dQ.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 100);
    if (!d_ack) check("d_timeout", 32'(d_ack), 1);
  endtask

  task automatic dIdle();
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;
    mem[8'h10] = 32'hA5A5A5A5;
    mem[8'h0C] = 32'h00000077;
    mem[8'h20] = 32'hBEEF0080;
    mem[8'h21] = 32'hBEEF0084;
    for (int k = 0; k < 9; k++) mem[8'h40 + k] = 32'h1000 + k;

    reset = 1'b0;
    p_read = 0; p_write = 0; p_addr = 0; p_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_d_ack", 32'(d_ack), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_p_rdata", p_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_p_stall_idle", 32'(p_stall), 0);
    p_read = 1'b1; #1;
    check("rst_p_stall_req", 32'(p_stall), 1);
    p_read = 1'b0;
    @(negedge clk); reset = 1'b1;

    // P load, P store, D reads (incl. read-back of the store), D write then P read-back
    pIssue(0, 32'h10, 0, 32'hDEADBEEF, LAT + 1); pIdle();
    pIssue(1, 32'h20, 32'h1234, 0, LAT + 1);     pIdle();
    dIssue(0, 32'h40, 0, 32'hA5A5A5A5, LAT + 1); dIdle();
    dIssue(0, 32'h20, 0, 32'h1234, LAT + 1);     dIdle();
    dIssue(1, 32'h44, 32'hCAFE, 0, LAT + 1);     dIdle();
    pIssue(0, 32'h44, 0, 32'hCAFE, LAT + 1);     pIdle();

    // P and D together with the starve counter at 0: D acked LAT+2 after P's RESP
    fork
      begin pIssue(0, 32'h10, 0, 32'hDEADBEEF, LAT + 1); pIdle(); end
      begin dIssue(0, 32'h40, 0, 32'hA5A5A5A5, 2 * LAT + 3); dIdle(); end
    join

    // Starvation: continuous P stream; D wins on the 5th arbitration, then the counter restarts
    fork
      begin
        for (int k = 0; k < 9; k++)
          pIssue(0, 32'h100 + 32'(4 * k), 0, 32'h1000 + 32'(k), (k == 4 || k == 8) ? 7 : 3);
        pIdle();
      end
      begin
        dIssue(0, 32'h80, 0, 32'hBEEF0080, 19);
        dIssue(0, 32'h84, 0, 32'hBEEF0084, 19);
        dIdle();
      end
    join

    // Reset in the 2nd ACCESS cycle aborts the load
    @(posedge clk); #1;
    p_read = 1'b1; p_addr = 32'h30;
    @(posedge clk); @(posedge clk); #1;
    check("abort_pre_strobe", 32'(mem_read), 1);
    #1 reset = 1'b0;
    #1;
    check("abort_mem_read", 32'(mem_read), 0);
    check("abort_mem_write", 32'(mem_write), 0);
    check("abort_d_ack", 32'(d_ack), 0);
    check("abort_p_rdata", p_rdata, 0);
    check("abort_p_stall", 32'(p_stall), 1);
    p_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    pIssue(0, 32'h30, 0, 32'h77, LAT + 1); pIdle();

    repeat (3) @(posedge clk);
    check("queues_drained", 32'(pQ.size() + dQ.size()), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
